// File: rtl/sram_axi_bridge_pkg.sv
// rtl/sram_axi_bridge_pkg.sv - shared state encodings and AXI constants for the SRAM-to-AXI bridge
package sram_axi_bridge_pkg;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_AR   = 2'd1,
    R_WAIT = 2'd2
  } rd_state_t;

  typedef enum logic [2:0] {
    W_IDLE = 3'd0,
    W_AW_W = 3'd1,
    W_W    = 3'd2,
    W_AW   = 3'd3,
    W_B    = 3'd4
  } wr_state_t;

  localparam logic [3:0] ARID_INST      = 4'd0;
  localparam logic [3:0] ARID_DATA      = 4'd1;
  localparam logic [3:0] AWID           = 4'd1;
  localparam logic [7:0] AXI_LEN        = 8'd0;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_LOCK       = 2'd0;
  localparam logic [3:0] AXI_CACHE      = 4'd0;
  localparam logic [2:0] AXI_PROT       = 3'd0;

  function automatic logic [2:0] axi_size(input logic [1:0] size);
    return {1'b0, size};
  endfunction

endpackage

// File: rtl/sram_axi_rd_ch.sv
// rtl/sram_axi_rd_ch.sv - read channel: arbitrates inst/data reads onto a single outstanding AR/R transfer
module sram_axi_rd_ch
  import sram_axi_bridge_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic        data_req,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  output logic        inst_addr_ok,
  output logic        data_addr_ok,
  output logic        inst_data_ok,
  output logic        data_data_ok,
  output logic        data_rd_busy,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [2:0]  arsize,
  output logic        arvalid,
  input  logic        arready,
  input  logic        rid_lsb,
  input  logic        rvalid,
  output logic        rready
);

  rd_state_t   state, state_nx;
  logic [31:0] addr_q;
  logic [1:0]  size_q;
  logic [3:0]  id_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state  <= R_IDLE;
      addr_q <= '0;
      size_q <= '0;
      id_q   <= '0;
    end else begin
      state <= state_nx;
      if (data_addr_ok) begin
        addr_q <= data_addr;
        size_q <= data_size;
        id_q   <= ARID_DATA;
      end else if (inst_addr_ok) begin
        addr_q <= inst_addr;
        size_q <= inst_size;
        id_q   <= ARID_INST;
      end
    end
  end

  // data_req arrives already qualified against the write side, so it simply wins here
  always_comb begin
    state_nx     = state;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    arvalid      = 1'b0;
    rready       = 1'b0;
    case (state)
      R_IDLE: begin
        data_addr_ok = data_req;
        inst_addr_ok = inst_req && !data_req;
        if (data_req || inst_req) state_nx = R_AR;
      end
      R_AR: begin
        arvalid = 1'b1;
        if (arready) state_nx = R_WAIT;
      end
      R_WAIT: begin
        rready = 1'b1;
        if (rvalid) begin
          data_data_ok = rid_lsb;
          inst_data_ok = !rid_lsb;
          state_nx     = R_IDLE;
        end
      end
      default: state_nx = R_IDLE;
    endcase
  end

  assign data_rd_busy = (state != R_IDLE) && (id_q == ARID_DATA);
  assign arid         = id_q;
  assign araddr       = addr_q;
  assign arsize       = axi_size(size_q);

endmodule

// File: rtl/sram_axi_bridge.sv
// rtl/sram_axi_bridge.sv - bridges fetch and load/store SRAM-like ports onto one AXI master
module sram_axi_bridge
  import sram_axi_bridge_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready
);

  wr_state_t   wr_state, wr_state_nx;
  logic [31:0] wr_addr_q, wr_data_q;
  logic [1:0]  wr_size_q;
  logic [3:0]  wr_strb_q;
  logic        wr_accept, wr_data_ok, wr_idle;
  logic        data_rd_req, data_rd_busy;
  logic        rd_data_addr_ok, rd_data_data_ok;
  logic        unused_inputs;

  assign unused_inputs = &{1'b0, inst_sram_wr, inst_sram_wstrb, inst_sram_wdata, rid[3:1], rresp, rlast};

  assign wr_idle     = (wr_state == W_IDLE);
  // data reads wait for any write to finish so a load never overtakes a store
  assign data_rd_req = data_sram_req && !data_sram_wr && wr_idle;

  sram_axi_rd_ch u_rd_ch (
    .clk          (clk),
    .resetn       (resetn),
    .inst_req     (inst_sram_req),
    .inst_size    (inst_sram_size),
    .inst_addr    (inst_sram_addr),
    .data_req     (data_rd_req),
    .data_size    (data_sram_size),
    .data_addr    (data_sram_addr),
    .inst_addr_ok (inst_sram_addr_ok),
    .data_addr_ok (rd_data_addr_ok),
    .inst_data_ok (inst_sram_data_ok),
    .data_data_ok (rd_data_data_ok),
    .data_rd_busy (data_rd_busy),
    .arid         (arid),
    .araddr       (araddr),
    .arsize       (arsize),
    .arvalid      (arvalid),
    .arready      (arready),
    .rid_lsb      (rid[0]),
    .rvalid       (rvalid),
    .rready       (rready)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_state  <= W_IDLE;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_size_q <= '0;
      wr_strb_q <= '0;
    end else begin
      wr_state <= wr_state_nx;
      if (wr_accept) begin
        wr_addr_q <= data_sram_addr;
        wr_data_q <= data_sram_wdata;
        wr_size_q <= data_sram_size;
        wr_strb_q <= data_sram_wstrb;
      end
    end
  end

  always_comb begin
    wr_state_nx = wr_state;
    wr_accept   = 1'b0;
    wr_data_ok  = 1'b0;
    awvalid     = 1'b0;
    wvalid      = 1'b0;
    bready      = 1'b0;
    case (wr_state)
      W_IDLE: begin
        if (data_sram_req && data_sram_wr && !data_rd_busy) begin
          wr_accept   = 1'b1;
          wr_state_nx = W_AW_W;
        end
      end
      W_AW_W: begin
        awvalid = 1'b1;
        wvalid  = 1'b1;
        if (awready && wready) wr_state_nx = W_B;
        else if (awready)      wr_state_nx = W_W;
        else if (wready)       wr_state_nx = W_AW;
      end
      W_W: begin
        wvalid = 1'b1;
        if (wready) wr_state_nx = W_B;
      end
      W_AW: begin
        awvalid = 1'b1;
        if (awready) wr_state_nx = W_B;
      end
      W_B: begin
        bready = 1'b1;
        if (bvalid) begin
          wr_data_ok  = 1'b1;
          wr_state_nx = W_IDLE;
        end
      end
      default: wr_state_nx = W_IDLE;
    endcase
  end

  // a data read and a data write are never outstanding together, so the two data_ok sources cannot collide
  assign data_sram_addr_ok = rd_data_addr_ok || wr_accept;
  assign data_sram_data_ok = rd_data_data_ok || wr_data_ok;
  assign inst_sram_rdata   = rdata;
  assign data_sram_rdata   = rdata;

  assign arlen   = AXI_LEN;
  assign arburst = AXI_BURST_INCR;
  assign arlock  = AXI_LOCK;
  assign arcache = AXI_CACHE;
  assign arprot  = AXI_PROT;
  assign awid    = AWID;
  assign awaddr  = wr_addr_q;
  assign awlen   = AXI_LEN;
  assign awsize  = axi_size(wr_size_q);
  assign awburst = AXI_BURST_INCR;
  assign awlock  = AXI_LOCK;
  assign awcache = AXI_CACHE;
  assign awprot  = AXI_PROT;
  assign wid     = AWID;
  assign wdata   = wr_data_q;
  assign wstrb   = wr_strb_q;
  assign wlast   = 1'b1;

endmodule
